// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the PC sequencer: NPC select codes, FSM encodings and the
// fixed PC vectors that the NPC mux and CP0 also rely on.
package pc_seq_ctrl_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_J    = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;
  localparam logic [2:0] NPC_EPC  = 3'b100;
  localparam logic [2:0] NPC_EXC  = 3'b101;
  localparam logic [2:0] NPC_BOOT = 3'b110;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_MASK = 2'b10
  } state_e;

  // Resolved action for one non-boot cycle, in decreasing priority.
  typedef enum logic [2:0] {
    ACT_FREEZE = 3'd0,
    ACT_EXC    = 3'd1,
    ACT_ERET   = 3'd2,
    ACT_STALL  = 3'd3,
    ACT_JR     = 3'd4,
    ACT_J      = 3'd5,
    ACT_BR     = 3'd6,
    ACT_SEQ    = 3'd7
  } act_e;

  // Merge new requests into the pending bits; an exception shadows a concurrent eret.
  function automatic logic [1:0] pend_merge(input logic pend_exc, input logic pend_eret,
                                            input logic exc_req, input logic eret_req);
    logic exc_n;
    exc_n = pend_exc | exc_req;
    return {exc_n, (pend_eret | eret_req) & ~exc_n};
  endfunction

endpackage

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: arbitrates redirects, stall and fetch freeze into the NPC select
// code, PC write enable and F/D, D/E flushes.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             freeze,
  input  logic             br_taken,
  input  logic             jmp,
  input  logic             jr,
  input  logic             exc_req,
  input  logic             eret_req,
  output logic [2:0]       npc_op,
  output logic             pc_we,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             exc_pending,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic              pend_exc_q, pend_exc_d;
  logic              pend_eret_q, pend_eret_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  act_e              act_s;
  logic [1:0]        pend_mrg_s;

  assign pend_mrg_s  = pend_merge(pend_exc_q, pend_eret_q, exc_req, eret_req);
  assign exc_pending = pend_exc_q | pend_eret_q;
  assign redir_cnt   = cnt_q;

  // State register and sequencer flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      pend_exc_q  <= 1'b0;
      pend_eret_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_exc_q  <= pend_exc_d;
      pend_eret_q <= pend_eret_d;
      cnt_q       <= cnt_d;
    end
  end

  // Priority encoder; redirects are only taken in RUN, MASK merely latches them.
  always_comb begin
    act_s = ACT_SEQ;
    if (freeze) begin
      act_s = ACT_FREEZE;
    end else if ((state_q == ST_RUN) && (exc_req || pend_exc_q)) begin
      act_s = ACT_EXC;
    end else if ((state_q == ST_RUN) && (eret_req || pend_eret_q)) begin
      act_s = ACT_ERET;
    end else if (stall) begin
      act_s = ACT_STALL;
    end else if (jr) begin
      act_s = ACT_JR;
    end else if (jmp) begin
      act_s = ACT_J;
    end else if (br_taken) begin
      act_s = ACT_BR;
    end else begin
      act_s = ACT_SEQ;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pend_exc_d  = pend_exc_q;
    pend_eret_d = pend_eret_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + BOOT_W'(1'b1);
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_RUN: begin
        if ((act_s == ACT_EXC) || (act_s == ACT_ERET)) begin
          pend_exc_d  = 1'b0;
          pend_eret_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1'b1);
          state_d     = ST_MASK;
        end else if (act_s == ACT_FREEZE) begin
          {pend_exc_d, pend_eret_d} = pend_mrg_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MASK: begin
        {pend_exc_d, pend_eret_d} = pend_mrg_s;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    npc_op   = NPC_SEQ;
    pc_we    = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    if (!reset) begin
      npc_op = NPC_BOOT;
    end else if (state_q == ST_BOOT) begin
      npc_op   = NPC_BOOT;
      pc_we    = 1'b1;
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else begin
      case (act_s)
        ACT_FREEZE: pc_we = 1'b0;
        ACT_EXC: begin
          npc_op   = NPC_EXC;
          pc_we    = 1'b1;
          flush_fd = 1'b1;
          flush_de = 1'b1;
        end
        ACT_ERET: begin
          npc_op   = NPC_EPC;
          pc_we    = 1'b1;
          flush_fd = 1'b1;
        end
        ACT_STALL: flush_de = 1'b1;
        ACT_JR: begin
          npc_op = NPC_JR;
          pc_we  = 1'b1;
        end
        ACT_J: begin
          npc_op = NPC_J;
          pc_we  = 1'b1;
        end
        ACT_BR: begin
          npc_op = NPC_BR;
          pc_we  = 1'b1;
        end
        default: begin
          npc_op = NPC_SEQ;
          pc_we  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: a default instance and a CNT_W=2 instance share
// stimulus; expectations are queued on drive and compared mid-cycle.
module tb_pc_seq_ctrl;
  import pc_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, freeze, br_taken, jmp, jr, exc_req, eret_req;
  logic [2:0]  npc_op, npc_op2;
  logic        pc_we, flush_fd, flush_de, exc_pending;
  logic        pc_we2, flush_fd2, flush_de2, exc_pending2;
  logic [15:0] redir_cnt;
  logic [1:0]  redir_cnt2;

  always #5 clk = ~clk;

  pc_seq_ctrl #(.BOOT_CYCLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .freeze(freeze), .br_taken(br_taken),
    .jmp(jmp), .jr(jr), .exc_req(exc_req), .eret_req(eret_req), .npc_op(npc_op),
    .pc_we(pc_we), .flush_fd(flush_fd), .flush_de(flush_de),
    .exc_pending(exc_pending), .redir_cnt(redir_cnt)
  );

  pc_seq_ctrl #(.BOOT_CYCLES(1), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .stall(stall), .freeze(freeze), .br_taken(br_taken),
    .jmp(jmp), .jr(jr), .exc_req(exc_req), .eret_req(eret_req), .npc_op(npc_op2),
    .pc_we(pc_we2), .flush_fd(flush_fd2), .flush_de(flush_de2),
    .exc_pending(exc_pending2), .redir_cnt(redir_cnt2)
  );

  // Input bit positions: {stall, freeze, br_taken, jmp, jr, exc_req, eret_req}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_S    = 7'b1000000;
  localparam logic [6:0] I_F    = 7'b0100000;
  localparam logic [6:0] I_B    = 7'b0010000;
  localparam logic [6:0] I_J    = 7'b0001000;
  localparam logic [6:0] I_R    = 7'b0000100;
  localparam logic [6:0] I_X    = 7'b0000010;
  localparam logic [6:0] I_E    = 7'b0000001;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        we, ffd, fde, pend;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    string      name;
    logic [6:0] in;
    logic [2:0] op;
    logic       we, ffd, fde;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic check();
    exp_t        e;
    logic [22:0] act_v, exp_v;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = sb_q.pop_front();
      act_v = {npc_op, pc_we, flush_fd, flush_de, exc_pending, redir_cnt};
      exp_v = {e.op, e.we, e.ffd, e.fde, e.pend, e.cnt};
      if (act_v !== exp_v ||
          {npc_op2, pc_we2, flush_fd2, flush_de2, exc_pending2, redir_cnt2} !==
          {e.op, e.we, e.ffd, e.fde, e.pend, e.cnt[1:0]}) begin
        n_fail++;
        $display("FAIL %s: got op=%b we=%b ffd=%b fde=%b pend=%b cnt=%0d | w2 op=%b we=%b ffd=%b fde=%b pend=%b cnt=%0d ; expected op=%b we=%b ffd=%b fde=%b pend=%b cnt=%0d cnt2=%0d",
                 e.name, npc_op, pc_we, flush_fd, flush_de, exc_pending, redir_cnt,
                 npc_op2, pc_we2, flush_fd2, flush_de2, exc_pending2, redir_cnt2,
                 e.op, e.we, e.ffd, e.fde, e.pend, e.cnt, e.cnt[1:0]);
      end
    end
  endtask

  task automatic drive(input string name, input logic [6:0] in, input logic [2:0] op,
                       input logic we, input logic ffd, input logic fde, input logic pend);
    exp_t e;
    {stall, freeze, br_taken, jmp, jr, exc_req, eret_req} = in;
    e.name = name; e.op = op; e.we = we; e.ffd = ffd; e.fde = fde; e.pend = pend;
    e.cnt  = 16'(exp_cnt);
    sb_q.push_back(e);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    if (reset && (op == NPC_EXC || op == NPC_EPC)) exp_cnt++;
  endtask

  initial begin
    vecs[0] = '{"run_idle",     I_NONE,          NPC_SEQ, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"run_br",       I_B,             NPC_BR,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{"run_j",        I_J,             NPC_J,   1'b1, 1'b0, 1'b0};
    vecs[3] = '{"run_jr",       I_R,             NPC_JR,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{"run_jr_j_br",  I_R | I_J | I_B, NPC_JR,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{"run_j_br",     I_J | I_B,       NPC_J,   1'b1, 1'b0, 1'b0};
    vecs[6] = '{"stall_br",     I_S | I_B,       NPC_SEQ, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{"stall_jr",     I_S | I_R,       NPC_SEQ, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{"frz_stall_jr", I_F | I_S | I_R, NPC_SEQ, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"frz_br",       I_F | I_B,       NPC_SEQ, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    {stall, freeze, br_taken, jmp, jr, exc_req, eret_req} = I_NONE;
    for (int i = 0; i < 3; i++) drive("in_reset", I_NONE, NPC_BOOT, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive("boot", I_NONE, NPC_BOOT, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("first_run", I_NONE, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++)
      drive(vecs[i].name, vecs[i].in, vecs[i].op, vecs[i].we, vecs[i].ffd, vecs[i].fde, 1'b0);

    // Exception overrides stall, then a MASK cycle behaving like RUN step 4.
    drive("exc_stall", I_S | I_X, NPC_EXC, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("mask_stall", I_S | I_R, NPC_SEQ, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("eret_stall", I_S | I_E, NPC_EPC, 1'b1, 1'b1, 1'b0, 1'b0);
    drive("mask_j", I_J, NPC_J, 1'b1, 1'b0, 1'b0, 1'b0);

    // Exception during freeze is held pending and applied on release.
    drive("frz_exc", I_F | I_X, NPC_SEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("frz_hold", I_F, NPC_SEQ, 1'b0, 1'b0, 1'b0, 1'b1);
    drive("frz_release", I_NONE, NPC_EXC, 1'b1, 1'b1, 1'b1, 1'b1);
    drive("after_release", I_NONE, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);

    // eret, then exc during MASK is latched and applied one cycle later.
    drive("eret", I_E, NPC_EPC, 1'b1, 1'b1, 1'b0, 1'b0);
    drive("mask_exc_latch", I_X, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("latched_exc", I_NONE, NPC_EXC, 1'b1, 1'b1, 1'b1, 1'b1);
    drive("mask_frz_eret", I_F | I_E, NPC_SEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("latched_eret", I_NONE, NPC_EPC, 1'b1, 1'b1, 1'b0, 1'b1);
    drive("mask_idle", I_NONE, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);

    // Both requests during freeze: exception wins.
    drive("frz_exc_eret", I_F | I_X | I_E, NPC_SEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("both_release", I_NONE, NPC_EXC, 1'b1, 1'b1, 1'b1, 1'b1);
    drive("both_mask", I_NONE, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("both_after", I_NONE, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-freeze with a pending exception clears everything.
    drive("rst_frz_exc", I_F | I_X, NPC_SEQ, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("rst_frz_pend", I_F, NPC_SEQ, 1'b0, 1'b0, 1'b0, 1'b1);
    reset   = 1'b0;
    exp_cnt = 0;
    drive("rst_mid", I_F, NPC_BOOT, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive("boot_ignores_req", I_F | I_X | I_E, NPC_BOOT, 1'b1, 1'b1, 1'b1, 1'b0);
    drive("post_boot", I_NONE, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);

    // Counter wrap on the narrow instance: 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      drive("wrap_exc", I_X, NPC_EXC, 1'b1, 1'b1, 1'b1, 1'b0);
      drive("wrap_mask", I_NONE, NPC_SEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
